// File: rtl/polaris_bus_arbiter_pkg.sv
// Shared definitions for the Polaris I/D bus arbiter: state encoding,
// bus size codes and default watchdog sizing.
package polaris_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_e;

  localparam logic [1:0] SIZ_B = 2'b00;
  localparam logic [1:0] SIZ_H = 2'b01;
  localparam logic [1:0] SIZ_W = 2'b10;
  localparam logic [1:0] SIZ_D = 2'b11;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/polaris_bus_arbiter_if.sv
// Signal bundle between the CPU I/D ports, the arbiter and the shared bus.
// The arbiter uses the slave view; the core/fabric side uses the master view.
interface polaris_bus_arbiter_if;
  logic        istb_i;
  logic [63:0] iadr_i;
  logic        iack_o;
  logic        ierr_o;
  logic [31:0] idat_o;

  logic        dcyc_i;
  logic        dstb_i;
  logic        dwe_i;
  logic [63:0] dadr_i;
  logic [63:0] ddat_i;
  logic [1:0]  dsiz_i;
  logic        dsigned_i;
  logic        dack_o;
  logic        derr_o;
  logic [63:0] ddat_o;

  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [63:0] adr_o;
  logic [63:0] dat_o;
  logic [1:0]  siz_o;
  logic        signed_o;
  logic        ack_i;
  logic [63:0] dat_i;

  modport slave (
    input  istb_i, iadr_i, dcyc_i, dstb_i, dwe_i, dadr_i, ddat_i, dsiz_i, dsigned_i,
    input  ack_i, dat_i,
    output iack_o, ierr_o, idat_o, dack_o, derr_o, ddat_o,
    output cyc_o, stb_o, we_o, adr_o, dat_o, siz_o, signed_o
  );

  modport master (
    output istb_i, iadr_i, dcyc_i, dstb_i, dwe_i, dadr_i, ddat_i, dsiz_i, dsigned_i,
    output ack_i, dat_i,
    input  iack_o, ierr_o, idat_o, dack_o, derr_o, ddat_o,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, siz_o, signed_o
  );
endinterface

// File: rtl/polaris_bus_arbiter_bus_watchdog.sv
// Per-transfer ack watchdog: counts strobe cycles without ack and pulses
// tmo_o on the TIMEOUT-th one. TIMEOUT=0 disables it; 2^CNT_W must exceed TIMEOUT.
module polaris_bus_arbiter_bus_watchdog
  import polaris_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic tmo_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An ack in the limit cycle wins: no pulse, counter clears.
  always_comb begin
    tmo_o = 1'b0;
    cnt_d = '0;
    if (TIMEOUT != 0 && stb_i && !ack_i) begin
      if (cnt_q == LIMIT) tmo_o = 1'b1;
      else                cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/polaris_bus_arbiter.sv
// Round-robin I/D arbiter onto one 64-bit bus, with a D-side lock held for
// the whole dcyc_i and a strobe watchdog that turns a missing ack into an error.
module polaris_bus_arbiter
  import polaris_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  polaris_bus_arbiter_if.slave bus,
  output logic [1:0]           gnt_o,
  output logic                 timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       dmask_q, dmask_d;
  logic       gnt_i, gnt_d, req_i, req_d, tmo;

  // Qualifying with reset_i keeps a mid-transfer ack from leaking out in the reset cycle.
  assign gnt_i = (state_q == GNT_I) && !reset_i;
  assign gnt_d = (state_q == GNT_D) && !reset_i;

  always_comb begin
    bus.cyc_o    = 1'b0;
    bus.stb_o    = 1'b0;
    bus.we_o     = 1'b0;
    bus.adr_o    = '0;
    bus.dat_o    = '0;
    bus.siz_o    = SIZ_B;
    bus.signed_o = 1'b0;
    if (gnt_i) begin
      bus.cyc_o = bus.istb_i;
      bus.stb_o = bus.istb_i;
      bus.adr_o = bus.iadr_i;
      bus.siz_o = SIZ_W;
    end else if (gnt_d) begin
      bus.cyc_o    = bus.dcyc_i;
      bus.stb_o    = bus.dstb_i;
      bus.we_o     = bus.dwe_i;
      bus.adr_o    = bus.dadr_i;
      bus.dat_o    = bus.ddat_i;
      bus.siz_o    = bus.dsiz_i;
      bus.signed_o = bus.dsigned_i;
    end
  end

  assign bus.iack_o = bus.ack_i && gnt_i && bus.istb_i;
  assign bus.dack_o = bus.ack_i && gnt_d && bus.dstb_i;
  assign bus.idat_o = !gnt_i ? 32'h0 : (bus.iadr_i[2] ? bus.dat_i[63:32] : bus.dat_i[31:0]);
  assign bus.ddat_o = gnt_d ? bus.dat_i : 64'h0;
  assign bus.ierr_o = tmo && gnt_i;
  assign bus.derr_o = tmo && gnt_d;
  assign gnt_o      = {gnt_d, gnt_i};
  assign timeout_o  = tmo;

  polaris_bus_arbiter_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .stb_i   (bus.stb_o),
    .ack_i   (bus.ack_i),
    .tmo_o   (tmo)
  );

  // After a D timeout the still-held dstb_i must not re-win arbitration.
  assign req_i = bus.istb_i;
  assign req_d = bus.dcyc_i && bus.dstb_i && !dmask_q;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    dmask_d  = dmask_q;
    if (dmask_q && !bus.dstb_i) dmask_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i && (!req_d || last_d_q)) begin
          state_d  = GNT_I;
          last_d_d = 1'b0;
        end else if (req_d) begin
          state_d  = GNT_D;
          last_d_d = 1'b1;
        end
      end
      GNT_I: begin
        if (bus.iack_o || bus.ierr_o || !bus.istb_i) state_d = IDLE;
      end
      GNT_D: begin
        if (!bus.dcyc_i || bus.derr_o) state_d = IDLE;
        if (bus.derr_o) dmask_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      dmask_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      dmask_q  <= dmask_d;
    end
  end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Bench for polaris_bus_arbiter: a vector table, scripted corner sequences
// and a randomized run against an ownership-level reference model.
module tb_polaris_bus_arbiter;
  import polaris_bus_arbiter_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  logic       tmo;

  polaris_bus_arbiter_if bus();

  polaris_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .bus       (bus),
    .gnt_o     (gnt),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, istb;
    logic [63:0] iadr;
    logic        dcyc, dstb, dwe;
    logic [63:0] dadr, ddat;
    logic [1:0]  dsiz;
    logic        dsigned, ack;
    logic [63:0] dat;
  } in_t;

  typedef struct packed {
    logic        cyc, stb, we;
    logic [63:0] adr, dat;
    logic [1:0]  siz;
    logic        sgn, iack, ierr;
    logic [31:0] idat;
    logic        dack, derr;
    logic [63:0] ddat;
    logic [1:0]  gnt;
    logic        tmo;
  } out_t;

  typedef struct packed {
    logic       rst, istb, dcyc, dstb, ack;
    logic [1:0] gnt;
    logic       stb, iack, dack, err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, whose turn a tie is, how long the
  // current strobe has waited, and whether D is locked out after a timeout.
  int m_owner  = 0;
  bit m_last_d = 1'b1;
  int m_wait   = 0;
  bit m_dblock = 1'b0;

  task automatic drive(input in_t v);
    rst           = v.rst;
    bus.istb_i    = v.istb;
    bus.iadr_i    = v.iadr;
    bus.dcyc_i    = v.dcyc;
    bus.dstb_i    = v.dstb;
    bus.dwe_i     = v.dwe;
    bus.dadr_i    = v.dadr;
    bus.ddat_i    = v.ddat;
    bus.dsiz_i    = v.dsiz;
    bus.dsigned_i = v.dsigned;
    bus.ack_i     = v.ack;
    bus.dat_i     = v.dat;
  endtask

  task automatic apply(input in_t v);
    drive(v);
    #4;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t sample();
    out_t o;
    o.cyc  = bus.cyc_o;   o.stb  = bus.stb_o;   o.we   = bus.we_o;
    o.adr  = bus.adr_o;   o.dat  = bus.dat_o;   o.siz  = bus.siz_o;
    o.sgn  = bus.signed_o; o.iack = bus.iack_o; o.ierr = bus.ierr_o;
    o.idat = bus.idat_o;  o.dack = bus.dack_o;  o.derr = bus.derr_o;
    o.ddat = bus.ddat_o;  o.gnt  = gnt;         o.tmo  = tmo;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input out_t got, input out_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, i, c, s, a, input logic [1:0] g,
                              input logic st, ia, da, er);
    vec_t v;
    v = '{r, i, c, s, a, g, st, ia, da, er};
    return v;
  endfunction

  function automatic out_t model_out(input in_t x);
    out_t o;
    bit   gi, gd;
    o  = '0;
    gi = (m_owner == 1) && !x.rst;
    gd = (m_owner == 2) && !x.rst;
    if (gi) begin
      o.cyc  = x.istb;
      o.stb  = x.istb;
      o.adr  = x.iadr;
      o.siz  = 2'b10;
      o.idat = x.iadr[2] ? x.dat[63:32] : x.dat[31:0];
      o.iack = x.ack && x.istb;
    end
    if (gd) begin
      o.cyc  = x.dcyc;
      o.stb  = x.dstb;
      o.we   = x.dwe;
      o.adr  = x.dadr;
      o.dat  = x.ddat;
      o.siz  = x.dsiz;
      o.sgn  = x.dsigned;
      o.ddat = x.dat;
      o.dack = x.ack && x.dstb;
    end
    o.gnt  = {gd, gi};
    o.tmo  = o.stb && !x.ack && (TO != 0) && (m_wait == TO - 1);
    o.ierr = o.tmo && gi;
    o.derr = o.tmo && gd;
    return o;
  endfunction

  task automatic model_step(input in_t x, input out_t o);
    bit ri, rd;
    if (x.rst) begin
      m_owner = 0; m_last_d = 1'b1; m_wait = 0; m_dblock = 1'b0;
      return;
    end
    case (m_owner)
      0: begin
        ri = x.istb;
        rd = x.dcyc && x.dstb && !m_dblock;
        if (ri && rd)  m_owner = m_last_d ? 1 : 2;
        else if (ri)   m_owner = 1;
        else if (rd)   m_owner = 2;
        if (m_owner != 0) m_last_d = (m_owner == 2);
      end
      1: if (o.iack || o.ierr || !x.istb) m_owner = 0;
      default: if (!x.dcyc || o.derr) m_owner = 0;
    endcase
    m_wait = (o.stb && !x.ack && !o.tmo) ? m_wait + 1 : 0;
    if (o.derr)       m_dblock = 1'b1;
    else if (!x.dstb) m_dblock = 1'b0;
  endtask

  initial begin
    in_t  x;
    out_t e;
    vec_t vt[$];
    logic [5:0] got6;

    x = '0; x.rst = 1'b1;
    drive(x);
    next();
    apply(x);
    chk_out("reset outputs", sample(), '0);
    next();

    // rst, istb, dcyc, dstb, ack -> gnt, stb, iack, dack, err
    vt.push_back(mk(1,0,0,0,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(0,1,0,0,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(0,1,0,0,0, 2'b01, 1,0,0,0));
    vt.push_back(mk(0,1,0,0,1, 2'b01, 1,1,0,0));
    vt.push_back(mk(0,0,0,0,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(1,0,0,0,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(0,1,1,1,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(0,1,1,1,0, 2'b01, 1,0,0,0));
    vt.push_back(mk(0,1,1,1,1, 2'b01, 1,1,0,0));
    vt.push_back(mk(0,1,1,1,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(0,1,1,1,0, 2'b10, 1,0,0,0));
    vt.push_back(mk(0,1,1,1,1, 2'b10, 1,0,1,0));
    vt.push_back(mk(0,1,0,0,0, 2'b10, 0,0,0,0));
    vt.push_back(mk(0,1,0,0,0, 2'b00, 0,0,0,0));
    vt.push_back(mk(0,1,0,0,0, 2'b01, 1,0,0,0));
    vt.push_back(mk(0,0,0,0,1, 2'b01, 0,0,0,0));
    vt.push_back(mk(0,0,0,0,1, 2'b00, 0,0,0,0));

    x = '0;
    x.iadr = 64'hFFFF_FFFF_FFFF_FF04;
    x.dadr = 64'h0000_0000_0000_0040;
    x.dat  = 64'hAAAA_BBBB_1111_2222;
    for (int i = 0; i < vt.size(); i++) begin
      x.rst = vt[i].rst; x.istb = vt[i].istb; x.dcyc = vt[i].dcyc;
      x.dstb = vt[i].dstb; x.ack = vt[i].ack;
      apply(x);
      got6 = {gnt, bus.stb_o, bus.iack_o, bus.dack_o, bus.ierr_o | bus.derr_o | tmo};
      chk($sformatf("tbl[%0d]", i), got6,
          {vt[i].gnt, vt[i].stb, vt[i].iack, vt[i].dack, vt[i].err});
      if (vt[i].gnt == 2'b01 && vt[i].stb) begin
        chk($sformatf("tbl[%0d] adr_o", i), bus.adr_o, 64'hFFFF_FFFF_FFFF_FF04);
        chk($sformatf("tbl[%0d] siz_o", i), bus.siz_o, SIZ_W);
      end
      if (vt[i].iack) chk($sformatf("tbl[%0d] idat_o", i), bus.idat_o, 32'hAAAA_BBBB);
      next();
    end

    // D lock: three strobes under one dcyc while I waits.
    x = '0; x.rst = 1'b1; apply(x); next();
    x.rst = 1'b0; x.iadr = 64'h2000;
    x.dcyc = 1; x.dstb = 1; x.dwe = 1; x.dadr = 64'h100;
    x.ddat = 64'h1122_3344_5566_7788; x.dsiz = SIZ_D;
    apply(x); chk("lock req gnt", gnt, 2'b00); next();
    x.istb = 1; x.ack = 1; apply(x);
    chk("lock w gnt", gnt, 2'b10); chk("lock w we", bus.we_o, 1);
    chk("lock w adr", bus.adr_o, 64'h100); chk("lock w dat", bus.dat_o, 64'h1122_3344_5566_7788);
    chk("lock w siz", bus.siz_o, SIZ_D); chk("lock w dack", bus.dack_o, 1);
    next();
    x.dstb = 0; x.dwe = 0; x.ack = 0; apply(x);
    chk("lock gap gnt", gnt, 2'b10); chk("lock gap stb", bus.stb_o, 0); next();
    x.dstb = 1; x.dadr = 64'h108; x.ack = 1; x.dat = 64'hCAFE_F00D_1234_5678; x.dsigned = 1;
    apply(x);
    chk("lock r1 gnt", gnt, 2'b10); chk("lock r1 dack", bus.dack_o, 1);
    chk("lock r1 ddat", bus.ddat_o, 64'hCAFE_F00D_1234_5678);
    chk("lock r1 signed", bus.signed_o, 1); chk("lock r1 idat", bus.idat_o, 0);
    chk("lock r1 iack", bus.iack_o, 0);
    next();
    x.dadr = 64'h110; apply(x);
    chk("lock r2 gnt", gnt, 2'b10); chk("lock r2 dack", bus.dack_o, 1); next();
    x.dcyc = 0; x.dstb = 0; x.ack = 0; x.dsigned = 0; apply(x);
    chk("lock rel gnt", gnt, 2'b10); chk("lock rel cyc", bus.cyc_o, 0); next();
    apply(x); chk("lock idle gnt", gnt, 2'b00); next();
    apply(x); chk("lock I gnt", gnt, 2'b01); chk("lock I adr", bus.adr_o, 64'h2000); next();
    x.ack = 1; apply(x);
    chk("lock I iack", bus.iack_o, 1); chk("lock I idat", bus.idat_o, 32'h1234_5678); next();
    x.istb = 0; x.ack = 0; apply(x); next();

    // I timeout, then the same transfer acked in the limit cycle.
    x.istb = 1; x.iadr = 64'h3000; apply(x); chk("ito req gnt", gnt, 2'b00); next();
    for (int k = 1; k <= TO; k++) begin
      apply(x);
      chk($sformatf("ito c%0d gnt", k), gnt, 2'b01);
      chk($sformatf("ito c%0d timeout", k), tmo, (k == TO));
      chk($sformatf("ito c%0d ierr", k), bus.ierr_o, (k == TO));
      chk($sformatf("ito c%0d iack", k), bus.iack_o, 0);
      next();
    end
    x.istb = 0; apply(x); chk("ito after gnt", gnt, 2'b00); next();
    x.istb = 1; apply(x); next();
    for (int k = 1; k <= TO; k++) begin
      x.ack = (k == TO); apply(x);
      chk($sformatf("iack4 c%0d iack", k), bus.iack_o, (k == TO));
      chk($sformatf("iack4 c%0d timeout", k), tmo, 0);
      chk($sformatf("iack4 c%0d ierr", k), bus.ierr_o, 0);
      next();
    end
    x.istb = 0; x.ack = 0; apply(x); chk("iack4 after gnt", gnt, 2'b00); next();

    // D timeout: held dstb_i stays locked out until it drops.
    x.dcyc = 1; x.dstb = 1; x.dadr = 64'h200; apply(x); next();
    for (int k = 1; k <= TO; k++) begin
      apply(x);
      chk($sformatf("dto c%0d gnt", k), gnt, 2'b10);
      chk($sformatf("dto c%0d derr", k), bus.derr_o, (k == TO));
      chk($sformatf("dto c%0d dack", k), bus.dack_o, 0);
      next();
    end
    apply(x); chk("dto mask1 gnt", gnt, 2'b00); chk("dto mask1 stb", bus.stb_o, 0); next();
    apply(x); chk("dto mask2 gnt", gnt, 2'b00); next();
    x.dstb = 0; apply(x); next();
    x.dstb = 1; apply(x); chk("dto rereq gnt", gnt, 2'b00); next();
    apply(x); chk("dto regrant gnt", gnt, 2'b10); chk("dto regrant stb", bus.stb_o, 1); next();

    // Reset during GNT_D with ack_i high, then ack_i while idle.
    x.rst = 1; x.ack = 1; apply(x);
    chk("rst dack", bus.dack_o, 0); chk("rst gnt", gnt, 2'b00); chk("rst stb", bus.stb_o, 0);
    next();
    x.rst = 0; apply(x); chk_out("post rst outputs", sample(), '0); next();
    x.ack = 0; apply(x); chk("post rst gnt", gnt, 2'b10); next();
    x.dcyc = 0; x.dstb = 0; apply(x); next();

    // Randomized run against the reference model.
    for (int k = 0; k < 3000; k++) begin
      x.rst     = (k == 0) || ($urandom_range(99) == 0);
      x.istb    = ($urandom_range(9) < 6);
      x.iadr    = {$urandom, $urandom};
      x.dcyc    = ($urandom_range(9) < 6);
      x.dstb    = ($urandom_range(9) < 7);
      x.dwe     = $urandom_range(1);
      x.dadr    = {$urandom, $urandom};
      x.ddat    = {$urandom, $urandom};
      x.dsiz    = 2'($urandom_range(3));
      x.dsigned = $urandom_range(1);
      x.ack     = ($urandom_range(9) < 2);
      x.dat     = {$urandom, $urandom};
      apply(x);
      e = model_out(x);
      chk_out($sformatf("rand cycle %0d", k), sample(), e);
      model_step(x, e);
      next();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
